// File: rtl/sort_frame_drain.sv
// Frame drain for the insertion sorter: checks in-frame ordering and forwards words through a
// one-entry output register. Optional statistics build: SORT_FRAME_DRAIN_STATS_EN.
module sort_frame_drain #(
   parameter int DATA_W     = 32,
   parameter int FRAME_LEN  = 8,
   parameter bit DESCENDING = 1'b0
) (
   input  logic              ap_clk,
   input  logic              ap_rst,
   input  logic              ap_start,
   output logic              ap_done,
   output logic              ap_idle,
   output logic              ap_ready,
   input  logic [DATA_W-1:0] in_V_dout,
   input  logic              in_V_empty_n,
   output logic              in_V_read,
   output logic [DATA_W-1:0] out_V_din,
   output logic              out_V_last,
   input  logic              out_V_full_n,
   output logic              out_V_write,
   output logic              order_err,
   output logic [15:0]       frame_cnt
);

   localparam int CNT_W = 8;
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH} state_t;

   state_t            r_state, w_state_nxt;
   logic [CNT_W-1:0]  r_cnt;
   logic [DATA_W-1:0] r_prev, r_dout;
   logic              r_wr, r_last, r_err;
   logic              w_accept, w_read, w_last_rd, w_viol;

   assign w_accept  = r_wr & out_V_full_n;
   assign w_last_rd = w_read & (r_cnt == LAST_IDX);
   // The first word of a frame has no predecessor, so it is never compared.
   assign w_viol    = (r_cnt != '0) &
                      (DESCENDING ? (in_V_dout > r_prev) : (in_V_dout < r_prev));

   always_ff @(posedge ap_clk or posedge ap_rst) begin
      if (ap_rst) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_read      = 1'b0;
      ap_done     = 1'b0;
      ap_idle     = 1'b0;
      case (r_state)
         S_IDLE: begin
            ap_idle = !r_wr;
            if (ap_start) w_state_nxt = S_RUN;
         end
         S_RUN: begin
            // Refill in the same cycle the register drains: one word per cycle sustained.
            w_read = in_V_empty_n & (!r_wr | out_V_full_n);
            if (w_read && r_cnt == LAST_IDX) w_state_nxt = S_FLUSH;
         end
         S_FLUSH: begin
            ap_done = w_accept;
            if (w_accept) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge ap_clk or posedge ap_rst) begin
      if (ap_rst) begin
         r_cnt  <= '0;
         r_prev <= '0;
         r_dout <= '0;
         r_wr   <= 1'b0;
         r_last <= 1'b0;
      end else if (w_read) begin
         r_dout <= in_V_dout;
         r_prev <= in_V_dout;
         r_wr   <= 1'b1;
         r_last <= w_last_rd;
         r_cnt  <= w_last_rd ? '0 : r_cnt + CNT_W'(1);
      end else if (w_accept) begin
         r_wr   <= 1'b0;
      end
   end

`ifdef SORT_FRAME_DRAIN_STATS_EN
   logic        w_start;
   logic [15:0] r_fcnt;

   assign w_start = (r_state == S_IDLE) & ap_start;

   always_ff @(posedge ap_clk or posedge ap_rst) begin
      if (ap_rst)                r_err <= 1'b0;
      else if (w_start)          r_err <= 1'b0;
      else if (w_read && w_viol) r_err <= 1'b1;
   end

   always_ff @(posedge ap_clk or posedge ap_rst) begin
      if (ap_rst)       r_fcnt <= '0;
      else if (ap_done) r_fcnt <= r_fcnt + 16'd1;
   end

   assign frame_cnt = r_fcnt;
`else
   always_ff @(posedge ap_clk or posedge ap_rst) begin
      if (ap_rst)                r_err <= 1'b0;
      else if (w_read && w_viol) r_err <= 1'b1;
   end

   assign frame_cnt = 16'h0;
`endif

   assign ap_ready    = w_last_rd;
   assign in_V_read   = w_read;
   assign out_V_din   = r_dout;
   assign out_V_last  = r_last;
   assign out_V_write = r_wr;
   assign order_err   = r_err;

endmodule

// File: tb/tb_sort_frame_drain.sv
// Randomized bench for sort_frame_drain: queue-based reference model of the frame stream,
// plus a FRAME_LEN=1 descending instance exercised with literal expectations.
module tb_sort_frame_drain;

   localparam int DW = 32;
   localparam int FL = 8;
`ifdef SORT_FRAME_DRAIN_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   typedef logic [DW-1:0] wq_t[$];
   typedef struct packed {
      logic [DW-1:0] d;
      logic          last;
   } ent_t;

   logic ap_clk = 1'b0;
   logic ap_rst = 1'b1;
   always #5 ap_clk = ~ap_clk;

   logic          ap_start, ap_done, ap_idle, ap_ready;
   logic          in_V_empty_n, in_V_read, out_V_last, out_V_full_n, out_V_write, order_err;
   logic [DW-1:0] in_V_dout, out_V_din;
   logic [15:0]   frame_cnt;

   logic          b_start, b_done, b_idle, b_ready, b_empty_n, b_read, b_last, b_full_n, b_write, b_err;
   logic [DW-1:0] b_dout, b_din;
   logic [15:0]   b_fcnt;

   sort_frame_drain #(.DATA_W(DW), .FRAME_LEN(FL), .DESCENDING(1'b0)) u_dut (
      .ap_clk(ap_clk), .ap_rst(ap_rst), .ap_start(ap_start), .ap_done(ap_done),
      .ap_idle(ap_idle), .ap_ready(ap_ready), .in_V_dout(in_V_dout),
      .in_V_empty_n(in_V_empty_n), .in_V_read(in_V_read), .out_V_din(out_V_din),
      .out_V_last(out_V_last), .out_V_full_n(out_V_full_n), .out_V_write(out_V_write),
      .order_err(order_err), .frame_cnt(frame_cnt));

   sort_frame_drain #(.DATA_W(DW), .FRAME_LEN(1), .DESCENDING(1'b1)) u_d1 (
      .ap_clk(ap_clk), .ap_rst(ap_rst), .ap_start(b_start), .ap_done(b_done),
      .ap_idle(b_idle), .ap_ready(b_ready), .in_V_dout(b_dout),
      .in_V_empty_n(b_empty_n), .in_V_read(b_read), .out_V_din(b_din),
      .out_V_last(b_last), .out_V_full_n(b_full_n), .out_V_write(b_write),
      .order_err(b_err), .frame_cnt(b_fcnt));

   // Reference model: upstream FIFO contents, words held downstream-bound, current frame words.
   wq_t         src_q;
   ent_t        exp_q[$];
   wq_t         frm;
   bit          m_active, m_reading, m_err;
   logic [15:0] m_fcnt;
   int n_done, cyc, tot, bad;
   int empty_pct = 100, full_pct = 100, full_low = 0, stall_after = -1, acc_in_frame = 0;
   bit start_drv;
   int rdy_cyc, done_cyc, first_rd_cyc;
   logic [DW-1:0] last_word;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      tot++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic cycle();
      bit   act0, rd_e, acc, lastw;
      ent_t e;
      @(negedge ap_clk);
      cyc++;
      ap_start     = start_drv;
      in_V_empty_n = (src_q.size() != 0) && ($urandom_range(0, 99) < empty_pct);
      in_V_dout    = (src_q.size() != 0) ? src_q[0] : $urandom;
      if (full_low > 0) begin
         out_V_full_n = 1'b0;
         full_low--;
      end else begin
         out_V_full_n = ($urandom_range(0, 99) < full_pct);
      end
      #1;
      act0  = m_active;
      rd_e  = m_reading && in_V_empty_n && (exp_q.size() == 0 || out_V_full_n);
      acc   = (exp_q.size() != 0) && out_V_full_n;
      lastw = (frm.size() == FL - 1);
      chk("in_V_read", in_V_read, rd_e);
      chk("ap_ready", ap_ready, rd_e && lastw);
      chk("ap_idle", ap_idle, !act0 && exp_q.size() == 0);
      chk("out_V_write", out_V_write, exp_q.size() != 0);
      if (exp_q.size() != 0) begin
         chk("out_V_din", out_V_din, exp_q[0].d);
         chk("out_V_last", out_V_last, exp_q[0].last);
         chk("ap_done", ap_done, acc && exp_q[0].last);
      end else begin
         chk("ap_done", ap_done, 1'b0);
      end
      chk("order_err", order_err, m_err);
      chk("frame_cnt", frame_cnt, STATS ? m_fcnt : 16'h0);

      if (acc) begin
         e = exp_q.pop_front();
         acc_in_frame++;
         if (acc_in_frame == stall_after) begin
            full_low    = 4;
            stall_after = -1;
         end
         if (e.last) begin
            m_active     = 1'b0;
            n_done++;
            done_cyc     = cyc;
            m_fcnt       = m_fcnt + 16'd1;
            last_word    = e.d;
            acc_in_frame = 0;
         end
      end
      if (start_drv && !act0) begin
         m_active  = 1'b1;
         m_reading = 1'b1;
         if (STATS) m_err = 1'b0;
      end
      if (rd_e) begin
         void'(src_q.pop_front());
         if (frm.size() == 0) first_rd_cyc = cyc;
         else if (in_V_dout < frm[frm.size()-1]) m_err = 1'b1;
         e.d    = in_V_dout;
         e.last = lastw;
         exp_q.push_back(e);
         frm.push_back(in_V_dout);
         if (lastw) begin
            frm.delete();
            m_reading = 1'b0;
            rdy_cyc   = cyc;
         end
      end
   endtask

   task automatic start_frame(input wq_t w);
      int guard = 0;
      foreach (w[i]) src_q.push_back(w[i]);
      while ((m_active || exp_q.size() != 0) && guard < 200) begin
         cycle();
         guard++;
      end
      start_drv = 1'b1;
      cycle();
      start_drv = 1'b0;
   endtask

   task automatic finish_frame(input int n0);
      int guard = 0;
      while (n_done == n0 && guard < 1000) begin
         cycle();
         guard++;
      end
      chk("frame_done_count", n_done - n0, 1);
   endtask

   task automatic run_frame(input wq_t w);
      int n0;
      n0 = n_done;
      start_frame(w);
      finish_frame(n0);
   endtask

   task automatic b_word(input logic [DW-1:0] w);
      @(negedge ap_clk);
      b_start = 1'b1; b_empty_n = 1'b1; b_dout = w;
      #1;
      chk("b_read_idle", b_read, 1'b0);
      chk("b_idle", b_idle, 1'b1);
      @(negedge ap_clk);
      b_start = 1'b0;
      #1;
      chk("b_read", b_read, 1'b1);
      chk("b_ready", b_ready, 1'b1);
      @(negedge ap_clk);
      b_empty_n = 1'b0;
      #1;
      chk("b_write", b_write, 1'b1);
      chk("b_din", b_din, w);
      chk("b_last", b_last, 1'b1);
      chk("b_done", b_done, 1'b1);
      chk("b_err", b_err, 1'b0);
      @(negedge ap_clk);
      #1;
      chk("b_write_after", b_write, 1'b0);
      chk("b_done_after", b_done, 1'b0);
      chk("b_idle_after", b_idle, 1'b1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      wq_t w;
      int  n0, guard;
      ap_start = 0; in_V_empty_n = 0; in_V_dout = '0; out_V_full_n = 1; start_drv = 0;
      b_start = 0; b_empty_n = 0; b_dout = '0; b_full_n = 1;
      m_fcnt = '0;
      repeat (2) @(negedge ap_clk);
      #1;
      chk("rst_write", out_V_write, 1'b0);
      chk("rst_last", out_V_last, 1'b0);
      chk("rst_din", out_V_din, '0);
      chk("rst_err", order_err, 1'b0);
      chk("rst_fcnt", frame_cnt, 16'h0);
      chk("rst_idle", ap_idle, 1'b1);
      chk("rst_done", ap_done, 1'b0);
      chk("rst_ready", ap_ready, 1'b0);
      chk("rst_read", in_V_read, 1'b0);
      @(negedge ap_clk);
      ap_rst = 1'b0;

      // Straight 1..8 with no backpressure.
      w = '{1, 2, 3, 4, 5, 6, 7, 8};
      run_frame(w);
      chk("t1_read_span", rdy_cyc - first_rd_cyc, 7);
      chk("t1_done_after_ready", done_cyc - rdy_cyc, 1);
      chk("t1_last_word", last_word, 8);
      chk("t1_err", order_err, 1'b0);
      chk("t1_fcnt", frame_cnt, STATS ? 16'd1 : 16'd0);

      w = '{5, 5, 7, 9, 9, 10, 20, 30};
      run_frame(w);
      chk("t2_err", order_err, 1'b0);

      w = '{1, 2, 3, 9, 4, 5, 6, 7};
      run_frame(w);
      chk("t3_err", order_err, 1'b1);
      chk("t3_last_word", last_word, 7);

      // Next frame: start clears the flag only in the statistics build; 4-cycle full stall.
      empty_pct   = 60;
      stall_after = 3;
      n0 = n_done;
      w = '{100, 101, 102, 103, 104, 105, 106, 107};
      start_frame(w);
      cycle();
      chk("t3_err_after_start", order_err, STATS ? 1'b0 : 1'b1);
      finish_frame(n0);
      chk("t4_last_word", last_word, 107);

      // Random frames: sorted and unsorted, random stalls on both sides.
      for (int f = 0; f < 10; f++) begin
         empty_pct = $urandom_range(40, 100);
         full_pct  = $urandom_range(40, 100);
         w.delete();
         for (int i = 0; i < FL; i++) w.push_back($urandom_range(0, 20));
         if (f < 6) w.sort();
         run_frame(w);
      end

      // Reset after 3 words read, then a clean frame.
      empty_pct = 100; full_pct = 100;
      w = '{1, 2, 3, 4, 5, 6, 7, 8};
      start_frame(w);
      guard = 0;
      while (frm.size() < 3 && guard < 100) begin
         cycle();
         guard++;
      end
      chk("t5_partial_reads", frm.size(), 3);
      @(negedge ap_clk);
      ap_rst = 1'b1; ap_start = 1'b0;
      #1;
      chk("t5_rst_write", out_V_write, 1'b0);
      chk("t5_rst_idle", ap_idle, 1'b1);
      chk("t5_rst_err", order_err, 1'b0);
      exp_q.delete(); src_q.delete(); frm.delete();
      m_active = 0; m_reading = 0; m_err = 0; m_fcnt = '0; acc_in_frame = 0;
      @(negedge ap_clk);
      ap_rst = 1'b0;
      w = '{10, 11, 12, 13, 14, 15, 16, 17};
      run_frame(w);
      chk("t5_last_word", last_word, 17);
      chk("t5_err", order_err, 1'b0);

      // Descending, one word per frame.
      b_word(9);
      b_word(3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", tot, bad);
      $finish;
   end

endmodule
